// File: rtl/aes_blk_ctrl.sv
// aes_blk_ctrl -- block sequencer in front of an iterative AES core.
// Takes one 128-bit block at a time from a valid/ready stream, launches the
// core by pulsing core_reset, waits for core_done under a watchdog, and
// returns the result on a second valid/ready stream. One block in flight.
// Optional feature macro: AES_BLK_CTRL_CBC_EN
//   defined   : CBC chaining around the core (uses cfg_iv)
//   undefined : ECB only, no chain register, cfg_iv ignored
module aes_blk_ctrl #(
   parameter int RST_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cfg_load,
   input  logic         cfg_mode,
   input  logic [127:0] cfg_key,
   input  logic [127:0] cfg_iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_last,
   output logic         core_reset,
   output logic         core_mode,
   output logic [127:0] core_data_in,
   output logic [127:0] core_key_in,
   input  logic [127:0] core_data_out,
   input  logic         core_done,
   output logic         busy,
   output logic         err
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2,
      ST_OUT    = 2'd3
   } state_t;

   state_t          state_r, state_next_s;
   logic [RC_W-1:0] rst_cnt_r;
   logic [WD_W-1:0] wd_r;

   logic            in_ready_r, out_valid_r, core_reset_r, busy_r, err_r;
   logic            in_ready_s, out_valid_s, core_reset_s, busy_s;
   logic            mode_r;
   logic [127:0]    key_r;
   logic [127:0]    core_din_r, out_data_r;
   logic            last_r, out_last_r;
   logic [127:0]    din_next_s, dout_next_s;

   logic            accept_s, cfg_take_s, done_s, timeout_s, out_fire_s;

`ifdef AES_BLK_CTRL_CBC_EN
   logic [127:0]    blk_r, iv_r, chain_r;
   logic [127:0]    eff_chain_s, chain_upd_s;
   logic            eff_mode_s;
`else
   logic            unused_iv_s;
   assign unused_iv_s = ^cfg_iv;
`endif

   // Handshake/event qualifiers; in_ready_r gates acceptance so the
   // post-reset cycle with in_ready low never takes a block.
   assign accept_s   = (state_r == ST_IDLE) & in_valid & in_ready_r;
   assign cfg_take_s = (state_r == ST_IDLE) & cfg_load;
   assign done_s     = (state_r == ST_RUN) & core_done;
   assign timeout_s  = (state_r == ST_RUN) & ~core_done & (wd_r == WD_LAST);
   assign out_fire_s = (state_r == ST_OUT) & out_valid_r & out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; core_done on the last watchdog cycle still wins.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_next_s = ST_LAUNCH;
            else          state_next_s = ST_IDLE;
         end
         ST_LAUNCH: begin
            if (rst_cnt_r == RC_LAST) state_next_s = ST_RUN;
            else                      state_next_s = ST_LAUNCH;
         end
         ST_RUN: begin
            if (core_done)             state_next_s = ST_OUT;
            else if (wd_r == WD_LAST)  state_next_s = ST_IDLE;
            else                       state_next_s = ST_RUN;
         end
         ST_OUT: begin
            if (out_ready) state_next_s = ST_IDLE;
            else           state_next_s = ST_OUT;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs track the state.
   always_comb begin
      in_ready_s   = 1'b0;
      out_valid_s  = 1'b0;
      core_reset_s = 1'b1;
      busy_s       = 1'b1;
      case (state_next_s)
         ST_IDLE: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b0;
         end
         ST_LAUNCH: begin
            core_reset_s = 1'b1;
         end
         ST_RUN: begin
            core_reset_s = 1'b0;
         end
         ST_OUT: begin
            out_valid_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Registered control outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         core_reset_r <= 1'b1;
         busy_r       <= 1'b0;
      end else begin
         in_ready_r   <= in_ready_s;
         out_valid_r  <= out_valid_s;
         core_reset_r <= core_reset_s;
         busy_r       <= busy_s;
      end
   end

   // Launch-length counter and RUN watchdog; both restart outside their state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt_r <= '0;
         wd_r      <= '0;
      end else begin
         if (state_r == ST_LAUNCH) rst_cnt_r <= rst_cnt_r + RC_W'(1);
         else                      rst_cnt_r <= '0;
         if (state_r == ST_RUN)    wd_r <= wd_r + WD_W'(1);
         else                      wd_r <= '0;
      end
   end

   // Latched configuration and sticky watchdog error.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_r <= 1'b0;
         key_r  <= 128'h0;
         err_r  <= 1'b0;
      end else begin
         if (cfg_take_s) begin
            mode_r <= cfg_mode;
            key_r  <= cfg_key;
         end
         if (cfg_take_s)     err_r <= 1'b0;
         else if (timeout_s) err_r <= 1'b1;
      end
   end

   // Core input for an accepted block (new config applies to it) and the
   // result/chain values produced when the core finishes.
   always_comb begin
`ifdef AES_BLK_CTRL_CBC_EN
      eff_mode_s  = cfg_take_s ? cfg_mode : mode_r;
      eff_chain_s = cfg_take_s ? cfg_iv : chain_r;
      if (eff_mode_s == 1'b0) din_next_s = in_data ^ eff_chain_s;
      else                    din_next_s = in_data;
      if (mode_r == 1'b0) begin
         dout_next_s = core_data_out;
         chain_upd_s = core_data_out;
      end else begin
         dout_next_s = core_data_out ^ chain_r;
         chain_upd_s = blk_r;
      end
`else
      din_next_s  = in_data;
      dout_next_s = core_data_out;
`endif
   end

   // Block datapath: core input held from LAUNCH through RUN, result held in OUT.
   always_ff @(posedge clk) begin
      if (reset) begin
         core_din_r <= 128'h0;
         last_r     <= 1'b0;
         out_data_r <= 128'h0;
         out_last_r <= 1'b0;
      end else begin
         if (accept_s) begin
            core_din_r <= din_next_s;
            last_r     <= in_last;
         end
         if (done_s) begin
            out_data_r <= dout_next_s;
            out_last_r <= last_r;
         end
      end
   end

`ifdef AES_BLK_CTRL_CBC_EN
   // CBC state: captured block, latched IV and running chain value; the chain
   // falls back to the IV after a timeout or after the last block of a message.
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_r   <= 128'h0;
         iv_r    <= 128'h0;
         chain_r <= 128'h0;
      end else begin
         if (accept_s)   blk_r <= in_data;
         if (cfg_take_s) iv_r  <= cfg_iv;
         if (cfg_take_s)                                  chain_r <= cfg_iv;
         else if (done_s)                                 chain_r <= chain_upd_s;
         else if (timeout_s | (out_fire_s & out_last_r))  chain_r <= iv_r;
      end
   end
`endif

   assign in_ready     = in_ready_r;
   assign out_valid    = out_valid_r;
   assign out_data     = out_data_r;
   assign out_last     = out_last_r;
   assign core_reset   = core_reset_r;
   assign core_mode    = mode_r;
   assign core_data_in = core_din_r;
   assign core_key_in  = key_r;
   assign busy         = busy_r;
   assign err          = err_r;

endmodule

// File: doc/aes_blk_ctrl.md
# aes_blk_ctrl

Block-sequencing controller placed in front of the iterative `AES` core. It accepts 128-bit blocks over a valid/ready stream, starts one core operation per block, waits for `aes_done`, and returns results over a second valid/ready stream. It also applies CBC chaining around the core and guards each core operation with a watchdog.

## Interface

**Parameters**
- `RST_CYCLES`, default 2: number of cycles `core_reset` is held high to launch one core operation (≥1).
- `TIMEOUT_CYCLES`, default 1023: maximum cycles to wait for `core_done` after `core_reset` is released.

**Ports**

Clock and reset are fixed: one clock, synchronous active-high reset.

- `clk` in 1: single clock; all logic uses the rising edge.
- `reset` in 1: synchronous, active-high reset.

Configuration:
- `cfg_load` in 1: single-cycle pulse that latches the configuration; honoured only in IDLE.
- `cfg_mode` in 1: 0 = encrypt, 1 = decrypt.
- `cfg_key` in 128: cipher key.
- `cfg_iv` in 128: CBC initialisation vector.

Input stream:
- `in_valid` in 1: input block valid.
- `in_ready` out 1: controller can accept a block.
- `in_data` in 128: input block.
- `in_last` in 1: marks the last block of a message.

Output stream:
- `out_valid` out 1: result block valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 128: result block.
- `out_last` out 1: copy of the `in_last` that went with this block.

Core side:
- `core_reset` out 1: drives the `AES` core `reset`; high launches an operation.
- `core_mode` out 1: driven from the latched mode.
- `core_data_in` out 128: block presented to the core.
- `core_key_in` out 128: driven from the latched key.
- `core_data_out` in 128: core result.
- `core_done` in 1: core `aes_done`.

Status:
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky watchdog flag; cleared by `reset` or `cfg_load`.

## Operation

**States:** IDLE, LAUNCH, RUN, OUT.

- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`, capture `in_data` into `blk` and `in_last` into `last_q`, then go to LAUNCH.
  - `cfg_load` in IDLE latches mode, key and IV, loads `chain` ← `cfg_iv`, and clears `err`.
  - If `cfg_load` and `in_valid` occur in the same cycle, the config is applied first and the block uses the new config.
  - `cfg_load` outside IDLE is ignored.
- **LAUNCH**
  - `core_reset` = 1 for exactly `RST_CYCLES` cycles (counter), then go to RUN.
  - `core_data_in` is registered and held stable from LAUNCH entry through the end of RUN.
- **RUN**
  - `core_reset` = 0 and the watchdog counter increments.
  - The first cycle with `core_done` = 1 captures `core_data_out`, updates `chain`, and goes to OUT.
  - If the watchdog reaches `TIMEOUT_CYCLES` without `core_done`: set `err`, drop the block (no output), restore `chain` to the latched IV, and go to IDLE.
- **OUT**
  - `out_valid` = 1 with `out_data` and `out_last` held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - If `out_last` was set, `chain` ← latched IV.

**Datapath, CBC enabled:**
- Encrypt:
  - `core_data_in` = `blk ^ chain`.
  - `out_data` = `core_data_out`.
  - `chain` ← `core_data_out`.
- Decrypt:
  - `core_data_in` = `blk`.
  - `out_data` = `core_data_out ^ chain`.
  - `chain` ← `blk`.

All XORs are full 128-bit. There is no other arithmetic.

## Timing

- **Reset values:**
  - Outputs: `in_ready`=0 during the reset cycle, then 1; `out_valid`=0; `out_data`=0; `out_last`=0; `core_reset`=1; `busy`=0; `err`=0.
  - Internal state: state = IDLE; mode=0, key=0, IV=0, `chain`=0.
- **Reset mid-operation:** aborts the operation, drops any pending output, and returns everything to the reset values.
- **Core idle:** `core_reset` is held high while in IDLE, so the core stays quiescent.
- **Latency:** input accept cycle T, then LAUNCH T+1..T+`RST_CYCLES`. RUN starts at T+`RST_CYCLES`+1. `out_valid` rises the cycle after `core_done` is sampled.
- **Throughput:** one block in flight. `in_ready` is 0 from the accept cycle +1 until the return to IDLE.
- **Back-pressure:** `out_valid` stays high indefinitely while `out_ready` = 0. Output is never dropped once in OUT.
- **Timeout boundary:** `core_done` arriving on the same cycle the watchdog reaches `TIMEOUT_CYCLES` counts as success.

## Configuration

- **Macro `AES_BLK_CTRL_CBC_EN`:**
  - Defined: the CBC datapath above is compiled in.
  - Undefined: ECB only. `core_data_in` = `blk`, `out_data` = `core_data_out`, the `chain` register is removed, and `cfg_iv` is ignored.
  - State machine, handshake and timing are identical in both builds.

## Test plan

1. **ECB encrypt, reference vector.** CBC off, `cfg_mode`=0, key `2b7e151628aed2a6abf7158809cf4f3c`, input `3243f6a8885a308d313198a2e0370734` → `out_data` `3925841d02dc09fbdc118597196a0b32`.
2. **ECB decrypt.** `cfg_mode`=1, same key, input `3925841d02dc09fbdc118597196a0b32` → `3243f6a8885a308d313198a2e0370734`.
3. **CBC encrypt, two-block chain.** CBC on, mode 0, IV `3243f6a8885a308d313198a2e0370734`. Block 0 = 0; block 1 = `0b6672b58a863976ed201d35f95d0c06` with `in_last`=1. Both outputs = `3925841d02dc09fbdc118597196a0b32`, and `out_last` is set on the second output only.
4. **CBC decrypt.** Feed both ciphertexts from scenario 3 with mode 1 → outputs `0…0` and `0b6672b58a863976ed201d35f95d0c06`.
5. **Back-pressure.** Hold `out_ready`=0 for 50 cycles after `out_valid` rises. `out_valid` and `out_data` stay stable, `in_ready` stays 0, and the result is accepted once `out_ready`=1.
6. **Watchdog.** Use a stub core that never asserts `core_done`, with `TIMEOUT_CYCLES`=16. `err` rises; `out_valid` is never asserted; state returns to IDLE with `in_ready`=1. A following `cfg_load` clears `err`.
